// File: rtl/led_pkg.sv
// led_pkg: shared BCD counter constants, state type and digit saturation helper
package led_pkg;
  localparam int BCD_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {RUN, PAUSE, LOAD} state_t;
  function automatic logic [BCD_W-1:0] sat_digit(input logic [BCD_W-1:0] d);
    return d > BCD_MAX ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/led_bcd_digit.sv
// led_bcd_digit: one BCD digit of the counter chain with load and carry/borrow out
// Ports: clk, rst_n (async active-low), step (advance this digit), up_dn (direction,
// used only when LED_BCD_COUNTER_DOWN_EN is defined), ld/ld_val (load, wins over step),
// digit (current value), cout (digit is at its roll-over value for the active direction).
module led_bcd_digit
  import led_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] digit,
  output logic             cout
);
  logic [BCD_W-1:0] nxt;
`ifdef LED_BCD_COUNTER_DOWN_EN
  assign cout = up_dn ? digit == BCD_MAX : digit == '0;
  assign nxt = up_dn ? (cout ? '0 : digit + 1'b1) : (cout ? BCD_MAX : digit - 1'b1);
`else
  logic unused_up_dn;
  assign unused_up_dn = up_dn;
  assign cout = digit == BCD_MAX;
  assign nxt = cout ? '0 : digit + 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) digit <= '0;
    else if (ld) digit <= ld_val;
    else if (step) digit <= nxt;
endmodule

// File: rtl/led_bcd_counter.sv
// led_bcd_counter: prescaled 4-digit BCD up(/down) counter with load handshake and clear
// Ports: clk, rst_n (async active-low), en (run/pause), clr (sync clear, highest priority),
// up_dn (direction), load_valid/load_bcd/load_ready (load handshake, digits >9 saturate to 9),
// bcd_out (count), bcd_upd (pulse with each new bcd_out value), wrap (pulse on roll-over).
// Macro LED_BCD_COUNTER_DOWN_EN enables down counting; otherwise up_dn is ignored.
module led_bcd_counter
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 20000000,
  parameter int TICK_HZ = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        up_dn,
  input  logic        load_valid,
  input  logic [15:0] load_bcd,
  output logic        load_ready,
  output logic [15:0] bcd_out,
  output logic        bcd_upd,
  output logic        wrap
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  state_t st, st_nxt;
  logic [PW-1:0] pre;
  logic [15:0] ld_reg, ld_sat, ld_src;
  logic tick, xfer, ld_now, step, upd_nxt;
  logic [NUM_DIGITS:0] chain;
  logic [NUM_DIGITS-1:0] cout;
  // clr blocks acceptance so a load never slips in behind a clear
  assign load_ready = rst_n && st != LOAD && !clr;
  assign xfer = load_valid && load_ready;
  assign tick = st == RUN && pre == PMAX;
  assign step = tick && !clr && !xfer;
  // clear is just a load of zero into every digit
  assign ld_now = clr || st == LOAD;
  assign ld_src = clr ? '0 : ld_reg;
  assign chain[0] = step;
  assign upd_nxt = ld_now ? ld_src != bcd_out : step;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign ld_sat[i*BCD_W +: BCD_W] = sat_digit(load_bcd[i*BCD_W +: BCD_W]);
    assign chain[i+1] = chain[i] && cout[i];
    led_bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (chain[i]),
      .up_dn  (up_dn),
      .ld     (ld_now),
      .ld_val (ld_src[i*BCD_W +: BCD_W]),
      .digit  (bcd_out[i*BCD_W +: BCD_W]),
      .cout   (cout[i])
    );
  end
  always_comb begin
    st_nxt = en ? RUN : PAUSE;
    if (xfer) st_nxt = LOAD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= PAUSE;
      pre <= '0;
      ld_reg <= '0;
      bcd_upd <= 1'b0;
      wrap <= 1'b0;
    end else begin
      st <= st_nxt;
      pre <= (clr || tick) ? '0 : st == RUN ? pre + 1'b1 : pre;
      ld_reg <= xfer ? ld_sat : ld_reg;
      bcd_upd <= upd_nxt;
      // a step that carries out of the top digit is a roll-over
      wrap <= chain[NUM_DIGITS];
    end
endmodule

// File: tb/tb_led_bcd_counter.sv
// tb_led_bcd_counter: self-checking bench for led_bcd_counter against an integer reference model
module tb_led_bcd_counter;
  localparam int DIV = 20;
  logic clk = 0, rst_n = 0, en = 0, clr = 0, up_dn = 1, load_valid = 0;
  logic [15:0] load_bcd = '0;
  logic load_ready, bcd_upd, wrap;
  logic [15:0] bcd_out;
  int n_chk = 0, n_pass = 0;
  int m_cnt, m_pre, m_ldv, m_st;
  bit m_upd, m_wrap;
  typedef struct {logic [15:0] lb; logic [15:0] exp;} vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  led_bcd_counter #(.CLK_HZ(20), .TICK_HZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .up_dn(up_dn),
    .load_valid(load_valid), .load_bcd(load_bcd), .load_ready(load_ready),
    .bcd_out(bcd_out), .bcd_upd(bcd_upd), .wrap(wrap)
  );

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v = n;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int sat_val(input logic [15:0] b);
    int v = 0, p = 1, d;
    for (int i = 0; i < 4; i++) begin
      d = int'(b[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // st encoding in the model: 0 run, 1 pause, 2 load
  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_ldv = 0; m_st = 1; m_upd = 0; m_wrap = 0;
  endtask

  task automatic model_edge();
    bit xfer, tick, up;
    int nv;
`ifdef LED_BCD_COUNTER_DOWN_EN
    up = up_dn;
`else
    up = 1;
`endif
    xfer = load_valid && m_st != 2 && !clr;
    tick = m_st == 0 && m_pre == DIV - 1;
    nv = m_cnt;
    m_wrap = 0;
    if (clr) nv = 0;
    else if (m_st == 2) nv = m_ldv;
    else if (tick && !xfer) begin
      nv = up ? (m_cnt + 1) % 10000 : (m_cnt + 9999) % 10000;
      m_wrap = up ? m_cnt == 9999 : m_cnt == 0;
    end
    m_upd = nv != m_cnt;
    m_cnt = nv;
    if (clr) m_pre = 0;
    else if (m_st == 0) m_pre = tick ? 0 : m_pre + 1;
    if (xfer) m_ldv = sat_val(load_bcd);
    m_st = xfer ? 2 : en ? 0 : 1;
  endtask

  task automatic cyc(input logic e, input logic c, input logic u, input logic lv, input logic [15:0] lb);
    en = e; clr = c; up_dn = u; load_valid = lv; load_bcd = lb;
    #1;
    chk("load_ready", load_ready, m_st != 2 && !c);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("bcd_out", bcd_out, to_bcd(m_cnt));
    chk("bcd_upd", bcd_upd, m_upd);
    chk("wrap", wrap, m_wrap);
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_bcd_out", bcd_out, 16'h0000);
    chk("rst_bcd_upd", bcd_upd, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_load_ready", load_ready, 1'b0);
    repeat (n) @(negedge clk);
    rst_n = 1;
  endtask

  // cycles from now until the count first changes, holding en=1 and up
  task automatic first_tick(input string nm);
    int n = 0, pulses = 0;
    logic [15:0] start = bcd_out;
    for (int k = 0; k < 40 && bcd_out == start; k++) begin
      cyc(1, 0, 1, 0, 16'h0);
      n++;
      pulses += int'(bcd_upd);
    end
    chk({nm, "_cycles"}, n, 21);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 1, 0, 16'h0);
      pulses += int'(bcd_upd);
    end
    chk({nm, "_upd_pulses"}, pulses, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wc, nchg;
    logic [15:0] vals[2], prev;
    logic wr[2];
    tbl[0] = '{16'h00A5, 16'h0095};
    tbl[1] = '{16'hFFFF, 16'h9999};
    tbl[2] = '{16'h1234, 16'h1234};
    tbl[3] = '{16'hA0B0, 16'h9090};
    tbl[4] = '{16'h0C09, 16'h0909};
    model_reset();
    @(negedge clk);
    en = 1;
    do_reset(2);
    first_tick("first_tick");
    chk("first_tick_val", bcd_out, 16'h0001);

    cyc(1, 0, 1, 1, 16'h9998);
    cyc(1, 0, 1, 0, 16'h0);
    chk("load_9998", bcd_out, 16'h9998);
    wc = 0;
    for (int k = 0; k < 60 && bcd_out != 16'h0000; k++) begin
      cyc(1, 0, 1, 0, 16'h0);
      wc += int'(wrap);
    end
    cyc(1, 0, 1, 0, 16'h0);
    wc += int'(wrap);
    chk("wrap_up_val", bcd_out, 16'h0000);
    chk("wrap_up_pulses", wc, 1);

    cyc(1, 0, 0, 1, 16'h0001);
    cyc(1, 0, 0, 0, 16'h0);
    nchg = 0;
    for (int k = 0; k < 60 && nchg < 2; k++) begin
      cyc(1, 0, 0, 0, 16'h0);
      if (bcd_upd) begin
        vals[nchg] = bcd_out;
        wr[nchg] = wrap;
        nchg++;
      end
    end
    chk("dir_steps_seen", nchg, 2);
`ifdef LED_BCD_COUNTER_DOWN_EN
    chk("down_first", vals[0], 16'h0000);
    chk("down_second", vals[1], 16'h9999);
    chk("down_wrap_first", wr[0], 1'b0);
    chk("down_wrap_second", wr[1], 1'b1);
`else
    chk("updn_ignored_first", vals[0], 16'h0002);
    chk("updn_ignored_second", vals[1], 16'h0003);
    chk("updn_ignored_wrap", wr[0] | wr[1], 1'b0);
`endif

    for (int k = 0; k < 40 && !(m_st == 0 && m_pre == DIV - 1); k++) cyc(1, 0, 1, 0, 16'h0);
    prev = bcd_out;
    cyc(1, 0, 1, 1, 16'h00A5);
    chk("tick_lost", bcd_out, prev);
    cyc(1, 0, 1, 0, 16'h0);
    chk("load_on_tick", bcd_out, 16'h0095);

    cyc(0, 0, 1, 1, 16'h0042);
    cyc(0, 0, 1, 0, 16'h0);
    chk("load_0042", bcd_out, 16'h0042);
    cyc(0, 1, 1, 1, 16'h0777);
    chk("clr_beats_load", bcd_out, 16'h0000);
    chk("clr_upd", bcd_upd, 1'b1);
    cyc(0, 0, 1, 0, 16'h0);
    cyc(0, 0, 1, 0, 16'h0);
    chk("clr_load_dropped", bcd_out, 16'h0000);
    cyc(0, 1, 1, 0, 16'h0);
    chk("clr_at_zero_no_upd", bcd_upd, 1'b0);

    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 1, tbl[i].lb);
      cyc(0, 0, 1, 0, 16'h0);
      chk("table_load", bcd_out, tbl[i].exp);
    end

    cyc(1, 0, 1, 1, 16'h1234);
    cyc(1, 0, 1, 0, 16'h0);
    chk("load_1234", bcd_out, 16'h1234);
    repeat (3) cyc(1, 0, 1, 0, 16'h0);
    do_reset(3);
    first_tick("post_reset_tick");

    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 14) == 0, 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
